// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared definitions for the MEM-stage load/store initiator.
//               Holds the FSM state encoding, RV32I funct3 width/sign codes,
//               byte-lane mask constants and the legality check helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // FSM state encoding
    localparam int         STATE_W    = 3;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR      = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    // funct3 codes (loads use all five, stores only the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-lane masks before shifting by the byte offset
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // An op is legal when its funct3 is a known code for its direction and
    // the byte offset is naturally aligned for the access width.
    function automatic logic op_legal(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
        logic code_ok;
        logic align_ok;
        if (we) begin
            code_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            code_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                      (f3 == F3_BU) || (f3 == F3_HU);
        end
        case (f3[1:0])
            2'b01:   align_ok = ~off[0];
            2'b10:   align_ok = (off == 2'b00);
            default: align_ok = 1'b1;
        endcase
        return code_ok && align_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load-data extraction. Shifts the addressed
//               byte/halfword down to lane 0 and sign- or zero-extends it
//               according to funct3.
// Ports       : read_data [31:0] in  - raw memory word
//               offset    [1:0]  in  - byte offset within the word
//               funct3    [2:0]  in  - load width/sign code
//               result    [31:0] out - extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] read_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] w_shifted;

    // Word loads are always at offset 0, so the shifted word is the raw word.
    assign w_shifted = read_data >> {offset, 3'b000};

    always_comb begin
        result = w_shifted;
        case (funct3)
            F3_B:    result = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    result = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   result = {24'd0, w_shifted[7:0]};
            F3_HU:   result = {16'd0, w_shifted[15:0]};
            default: result = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage load/store initiator. Converts a pipeline memory
//               op into single-cycle data-memory requests, builds byte masks
//               and replicated store data, waits for read data with a
//               timeout, aligns/extends loads and stalls the pipeline until
//               the access completes. Flags illegal ops and read timeouts.
// Ports       : clk, rst                       - clock, async active-high reset
//               mem_req, mem_we, funct3, addr,
//               store_data                     - pipeline op in
//               stall, done, load_data, fault  - pipeline status out
//               request, load, w_en, address,
//               write_data, masking            - memory request out
//               valid, read_data               - memory response in
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              fault,
    output logic              request,
    output logic              load,
    output logic              w_en,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    output logic [3:0]        masking,
    input  logic              valid,
    input  logic [31:0]       read_data
);

    localparam int                c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_address;
    logic [31:0]        r_write_data;
    logic [3:0]         r_masking;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic [31:0]        r_load_data;
    logic               r_timeout;

    logic               w_legal;
    logic               w_take;
    logic               w_accept;
    logic [3:0]         w_st_mask;
    logic [31:0]        w_st_data;
    logic [31:0]        w_aligned;
    logic               w_unused_addr_hi;

    assign w_unused_addr_hi = &{1'b0, addr[31:ADDR_W+2]};

    assign w_legal  = op_legal(mem_we, funct3, addr[1:0]);
    // Requests are not taken while reset is asserted, so every output reads
    // zero during reset even if the pipeline still holds mem_req high.
    assign w_take   = mem_req && !rst;
    assign w_accept = (r_state == ST_IDLE) && w_take && w_legal;

    // Store lane placement: shift the mask to the byte offset and replicate
    // the data so the addressed lanes carry the right bytes.
    always_comb begin
        w_st_mask = MASK_W;
        w_st_data = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_st_mask = MASK_B << addr[1:0];
                w_st_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_st_mask = MASK_H << addr[1:0];
                w_st_data = {2{store_data[15:0]}};
            end
            default: begin
                w_st_mask = MASK_W;
                w_st_data = store_data;
            end
        endcase
    end

    load_align u_load_align (
        .read_data (read_data),
        .offset    (r_off),
        .funct3    (r_funct3),
        .result    (w_aligned)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and outputs. Bus strobes depend only on r_state; the IDLE
    // accept/illegal responses are combinational on the presented op.
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        done         = 1'b0;
        fault        = 1'b0;
        request      = 1'b0;
        load         = 1'b0;
        w_en         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    if (w_legal) begin
                        stall        = 1'b1;
                        w_next_state = mem_we ? ST_WR : ST_RD_REQ;
                    end else begin
                        done  = 1'b1;
                        fault = 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                stall        = 1'b1;
                request      = 1'b1;
                load         = 1'b1;
                w_next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                stall = 1'b1;
                if (valid || (r_cnt == c_cnt_last)) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_WR: begin
                stall        = 1'b1;
                request      = 1'b1;
                w_en         = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                done         = 1'b1;
                fault        = r_timeout;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: request latches, timeout counter and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_address    <= '0;
            r_write_data <= '0;
            r_masking    <= '0;
            r_funct3     <= '0;
            r_off        <= '0;
            r_load_data  <= '0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_address    <= addr[ADDR_W+1:2];
                r_masking    <= mem_we ? w_st_mask : 4'b0000;
                r_write_data <= w_st_data;
                r_funct3     <= funct3;
                r_off        <= addr[1:0];
                r_timeout    <= 1'b0;
            end
            case (r_state)
                ST_RD_REQ: begin
                    r_cnt <= '0;
                end
                ST_RD_WAIT: begin
                    if (valid) begin
                        r_load_data <= w_aligned;
                    end else if (r_cnt == c_cnt_last) begin
                        r_load_data <= '0;
                        r_timeout   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign address    = r_address;
    assign write_data = r_write_data;
    assign masking    = r_masking;
    assign load_data  = r_load_data;

endmodule
`default_nettype wire
